// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state encoding, timeout default and opcodes shared by the CPU control path
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_MEM    = 3'b100,
        ST_WB     = 3'b101
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 15;

    localparam logic [3:0] OP_ALU = 4'h0;
    localparam logic [3:0] OP_HLT = 4'hE;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - shared instruction/data memory port handshake
interface multicycle_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive memory wait cycles and flags expiry
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expires in the wait cycle that brings the count up to LIMIT.
    assign expire = inc && !clr && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle control sequencer for the 16-bit RISC datapath
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    step_mode,
    input  logic                    dec_rf_we,
    input  logic                    dec_mem_we,
    input  logic                    dec_mem_rd,
    input  logic                    dec_hlt,
    multicycle_sequencer_if.master  mem,
    output logic                    ir_load,
    output logic                    rf_write_en,
    output logic                    pc_write_en,
    output logic                    halted,
    output logic                    bus_err,
    output logic [CNT_W-1:0]        instr_count,
    output logic [2:0]              state
);

    state_e           state_q;
    state_e           state_d;
    logic             bus_err_q;
    logic             bus_err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             retire;
    logic             req;
    logic             wait_cyc;
    logic             expire;

    // Memory request is a pure state decode so the timer sees no path back through the FSM.
    assign req      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_cyc = req && !mem.mem_ready;

    assign mem.mem_req      = req;
    assign mem.mem_addr_sel = (state_q == ST_MEM);
    assign mem.mem_we       = (state_q == ST_MEM) && dec_mem_we;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!wait_cyc),
        .inc    (wait_cyc),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        bus_err_d   = bus_err_q;
        retire      = 1'b0;
        ir_load     = 1'b0;
        rf_write_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bus_err_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (expire) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mem.mem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_hlt) begin
                    retire = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_mem_rd || dec_mem_we) begin
                    state_d = ST_MEM;
                end else if (dec_rf_we) begin
                    state_d = ST_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                if (expire) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mem.mem_ready) begin
                    if (dec_mem_we) begin
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_write_en = 1'b1;
                retire      = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only DECODE retires a HLT, so it always returns to IDLE.
        if (retire) begin
            state_d = (step_mode || state_q == ST_DECODE) ? ST_IDLE : ST_FETCH;
        end

        pc_write_en = retire;
        cnt_d       = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_IDLE);
    assign bus_err     = bus_err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        dec_rf_we;
    logic        dec_mem_we;
    logic        dec_mem_rd;
    logic        dec_hlt;
    logic        ir_load;
    logic        rf_write_en;
    logic        pc_write_en;
    logic        halted;
    logic        bus_err;
    logic [15:0] instr_count;
    logic [2:0]  state;

    multicycle_sequencer_if mif ();

    multicycle_sequencer #(
        .CNT_W       (16),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step_mode   (step_mode),
        .dec_rf_we   (dec_rf_we),
        .dec_mem_we  (dec_mem_we),
        .dec_mem_rd  (dec_mem_rd),
        .dec_hlt     (dec_hlt),
        .mem         (mif),
        .ir_load     (ir_load),
        .rf_write_en (rf_write_en),
        .pc_write_en (pc_write_en),
        .halted      (halted),
        .bus_err     (bus_err),
        .instr_count (instr_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Record: {state, mem_req, mem_we, mem_addr_sel, ir_load, rf_we, pc_we, halted, bus_err, instr_count}
    logic [26:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic cyc(input string nm, input logic [2:0] st, input logic [5:0] strb,
                       input logic err, input int cnt);
        exp_q.push_back({st, strb, (st == 3'd0), err, cnt[15:0]});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [26:0] e;
            logic [26:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_load, rf_write_en,
                  pc_write_en, halted, bus_err, instr_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d strb=%b halt=%b err=%b cnt=%0d, expected st=%0d strb=%b halt=%b err=%b cnt=%0d",
                         nm, a[26:24], a[23:18], a[17], a[16], a[15:0],
                         e[26:24], e[23:18], e[17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; step_mode = 1'b1;
        dec_rf_we = 1'b0; dec_mem_we = 1'b0; dec_mem_rd = 1'b0; dec_hlt = 1'b0;
        mif.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 3'd0, 6'b000000, 1'b0, 0);
        rst = 1'b0;
        cyc("idle_hold", 3'd0, 6'b000000, 1'b0, 0);

        // ADD, step mode
        dec_rf_we = 1'b1; start = 1'b1;
        cyc("add_idle", 3'd0, 6'b000000, 1'b0, 0);
        start = 1'b0;
        cyc("add_fetch", 3'd1, 6'b100100, 1'b0, 0);
        cyc("add_dec",   3'd2, 6'b000000, 1'b0, 0);
        cyc("add_exec",  3'd3, 6'b000000, 1'b0, 0);
        cyc("add_wb",    3'd5, 6'b000011, 1'b0, 0);
        cyc("add_done",  3'd0, 6'b000000, 1'b0, 1);

        // LDR with two MEM wait cycles
        dec_mem_rd = 1'b1; start = 1'b1;
        cyc("ldr_idle", 3'd0, 6'b000000, 1'b0, 1);
        start = 1'b0;
        cyc("ldr_fetch", 3'd1, 6'b100100, 1'b0, 1);
        cyc("ldr_dec",   3'd2, 6'b000000, 1'b0, 1);
        cyc("ldr_exec",  3'd3, 6'b000000, 1'b0, 1);
        mif.mem_ready = 1'b0;
        cyc("ldr_mem_w1", 3'd4, 6'b101000, 1'b0, 1);
        cyc("ldr_mem_w2", 3'd4, 6'b101000, 1'b0, 1);
        mif.mem_ready = 1'b1;
        cyc("ldr_mem_rdy", 3'd4, 6'b101000, 1'b0, 1);
        cyc("ldr_wb",      3'd5, 6'b000011, 1'b0, 1);
        cyc("ldr_done",    3'd0, 6'b000000, 1'b0, 2);

        // STR with one MEM wait, retires on the ready cycle
        dec_rf_we = 1'b0; dec_mem_rd = 1'b0; dec_mem_we = 1'b1; start = 1'b1;
        cyc("str_idle", 3'd0, 6'b000000, 1'b0, 2);
        start = 1'b0;
        cyc("str_fetch", 3'd1, 6'b100100, 1'b0, 2);
        cyc("str_dec",   3'd2, 6'b000000, 1'b0, 2);
        cyc("str_exec",  3'd3, 6'b000000, 1'b0, 2);
        mif.mem_ready = 1'b0;
        cyc("str_mem_w", 3'd4, 6'b111000, 1'b0, 2);
        mif.mem_ready = 1'b1;
        cyc("str_mem_rdy", 3'd4, 6'b111001, 1'b0, 2);
        cyc("str_done",    3'd0, 6'b000000, 1'b0, 3);

        // Two BEQ in step mode
        dec_mem_we = 1'b0; start = 1'b1;
        cyc("beq1_idle", 3'd0, 6'b000000, 1'b0, 3);
        start = 1'b0;
        cyc("beq1_fetch", 3'd1, 6'b100100, 1'b0, 3);
        cyc("beq1_dec",   3'd2, 6'b000000, 1'b0, 3);
        cyc("beq1_exec",  3'd3, 6'b000001, 1'b0, 3);
        cyc("beq1_done",  3'd0, 6'b000000, 1'b0, 4);
        cyc("beq_wait",   3'd0, 6'b000000, 1'b0, 4);
        start = 1'b1;
        cyc("beq2_idle", 3'd0, 6'b000000, 1'b0, 4);
        start = 1'b0;
        cyc("beq2_fetch", 3'd1, 6'b100100, 1'b0, 4);
        cyc("beq2_dec",   3'd2, 6'b000000, 1'b0, 4);
        cyc("beq2_exec",  3'd3, 6'b000001, 1'b0, 4);
        cyc("beq2_done",  3'd0, 6'b000000, 1'b0, 5);

        // Free run: BEQ falls straight into the next FETCH, then HLT stops
        step_mode = 1'b0; start = 1'b1;
        cyc("run_idle", 3'd0, 6'b000000, 1'b0, 5);
        start = 1'b0;
        cyc("run_fetch1", 3'd1, 6'b100100, 1'b0, 5);
        cyc("run_dec1",   3'd2, 6'b000000, 1'b0, 5);
        cyc("run_exec1",  3'd3, 6'b000001, 1'b0, 5);
        dec_hlt = 1'b1;
        cyc("run_fetch2", 3'd1, 6'b100100, 1'b0, 6);
        cyc("run_hlt",    3'd2, 6'b000001, 1'b0, 6);
        cyc("run_done",   3'd0, 6'b000000, 1'b0, 7);

        // HLT with start pulses outside IDLE ignored
        start = 1'b1;
        cyc("hlt_idle", 3'd0, 6'b000000, 1'b0, 7);
        mif.mem_ready = 1'b0;
        cyc("hlt_fetch_w", 3'd1, 6'b100000, 1'b0, 7);
        mif.mem_ready = 1'b1;
        cyc("hlt_fetch", 3'd1, 6'b100100, 1'b0, 7);
        cyc("hlt_dec",   3'd2, 6'b000001, 1'b0, 7);
        start = 1'b0;
        cyc("hlt_done",  3'd0, 6'b000000, 1'b0, 8);
        cyc("hlt_stay",  3'd0, 6'b000000, 1'b0, 8);

        // MEM timeout after 15 wait cycles, no retire
        dec_hlt = 1'b0; dec_mem_rd = 1'b1; step_mode = 1'b1; start = 1'b1;
        cyc("tmo_idle", 3'd0, 6'b000000, 1'b0, 8);
        start = 1'b0;
        cyc("tmo_fetch", 3'd1, 6'b100100, 1'b0, 8);
        cyc("tmo_dec",   3'd2, 6'b000000, 1'b0, 8);
        cyc("tmo_exec",  3'd3, 6'b000000, 1'b0, 8);
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("tmo_mem_w%0d", i + 1), 3'd4, 6'b101000, 1'b0, 8);
        end
        cyc("tmo_err", 3'd0, 6'b000000, 1'b1, 8);
        start = 1'b1;
        cyc("tmo_err_held", 3'd0, 6'b000000, 1'b1, 8);
        start = 1'b0;
        cyc("tmo_err_clr", 3'd1, 6'b100000, 1'b0, 8);
        mif.mem_ready = 1'b1;
        cyc("rst_fetch", 3'd1, 6'b100100, 1'b0, 8);
        cyc("rst_dec",   3'd2, 6'b000000, 1'b0, 8);
        cyc("rst_exec",  3'd3, 6'b000000, 1'b0, 8);
        mif.mem_ready = 1'b0;
        cyc("rst_mem", 3'd4, 6'b101000, 1'b0, 8);

        // Asynchronous reset mid-MEM
        rst = 1'b1;
        cyc("rst_mid", 3'd0, 6'b000000, 1'b0, 0);
        rst = 1'b0;
        cyc("post_rst", 3'd0, 6'b000000, 1'b0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
